// File: rtl/spi_adapter_pkg.sv
// rtl/spi_adapter_pkg.sv - shared sizing helpers and error-bit indices for the SPI minion adapter
package spi_adapter_pkg;

  localparam int ERR_WR = 0;
  localparam int ERR_RD = 1;

  function automatic int calc_abits(input int nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

  function automatic int calc_pw(input int nbits, input int nchan);
    return nbits - 2 - calc_abits(nchan);
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - round-robin grant over nchan requests; pointer moves past the winner on a pop
module spi_rr_arbiter
  import spi_adapter_pkg::*;
#(
  parameter int nchan = 2,
  localparam int ABITS = calc_abits(nchan)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nchan-1:0] req,
  input  logic             advance,
  output logic [nchan-1:0] grant,
  output logic [ABITS-1:0] grant_id,
  output logic             any_req
);

  logic [ABITS-1:0] ptr;
  logic [ABITS-1:0] next_ptr;
  int               idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any_req  = 1'b0;
    idx      = 0;
    for (int i = 0; i < nchan; i++) begin
      idx = (int'(ptr) + i) % nchan;
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ABITS'(idx);
      end
    end
  end

  assign next_ptr = ABITS'((int'(grant_id) + 1) % nchan);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance && any_req) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/vc_Queue.sv
// rtl/vc_Queue.sv - normal (non-bypass) circular-buffer val/rdy queue with free-entry count
module vc_Queue #(
  parameter int p_msg_nbits = 8,
  parameter int p_num_msgs  = 2,
  localparam int CW = $clog2(p_num_msgs + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic [CW-1:0]          num_free_entries
);

  localparam int AW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam logic [AW-1:0] LAST  = AW'(p_num_msgs - 1);
  localparam logic [CW-1:0] DEPTH = CW'(p_num_msgs);

  logic [p_msg_nbits-1:0] mem [p_num_msgs];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   do_enq;
  logic                   do_deq;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  // Full is decided on the registered count only, so a pop never frees a slot in the same cycle.
  assign enq_rdy          = (count != DEPTH);
  assign deq_val          = (count != '0);
  assign do_enq           = enq_val & enq_rdy;
  assign do_deq           = deq_val & deq_rdy;
  assign deq_msg          = mem[rd_ptr];
  assign num_free_entries = DEPTH - count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= bump(wr_ptr);
      if (do_deq) rd_ptr <= bump(rd_ptr);
      case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/spi_minion_adapter_mc.sv
// rtl/spi_minion_adapter_mc.sv - SPI minion push/pull to nchan val/rdy channels with RR read arbitration
module spi_minion_adapter_mc
  import spi_adapter_pkg::*;
#(
  parameter int nbits       = 8,
  parameter int nchan       = 2,
  parameter int num_entries = 2,
  localparam int ABITS = calc_abits(nchan),
  localparam int PW    = calc_pw(nbits, nchan),
  localparam int FW    = $clog2(num_entries + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_en,
  input  logic                  push_msg_val_wrt,
  input  logic                  push_msg_val_rd,
  input  logic [nbits-3:0]      push_msg_data,
  input  logic                  pull_en,
  output logic                  pull_msg_val,
  output logic                  pull_msg_spc,
  output logic [nbits-3:0]      pull_msg_data,
  input  logic [nchan*PW-1:0]   recv_msg,
  input  logic [nchan-1:0]      recv_val,
  output logic [nchan-1:0]      recv_rdy,
  output logic [nchan*PW-1:0]   send_msg,
  output logic [nchan-1:0]      send_val,
  input  logic [nchan-1:0]      send_rdy,
  output logic [nchan-1:0]      parity,
  output logic [1:0]            err
);

  logic [ABITS-1:0] wr_addr;
  logic [PW-1:0]    wr_payload;
  logic             wr;
  logic             rd;
  logic             pop_rd;
  logic             wr_drop;
  logic [nchan-1:0] wr_target;
  logic [nchan-1:0] out_enq_rdy;
  logic [nchan-1:0] in_enq_rdy;
  logic [nchan-1:0] in_deq_val;
  logic [nchan-1:0] spc_ok;
  logic [nchan-1:0] grant;
  logic [ABITS-1:0] grant_id;
  logic             any_ne;
  logic [FW-1:0]    out_free [nchan];
  logic [FW-1:0]    in_free  [nchan];
  logic [PW-1:0]    in_head  [nchan];

  assign wr_addr    = push_msg_data[nbits-3 -: ABITS];
  assign wr_payload = push_msg_data[PW-1:0];
  assign wr         = reset & push_en & push_msg_val_wrt;
  assign rd         = reset & pull_en & push_msg_val_rd;

  // An out-of-range address matches no channel, so it falls into the same drop path as a full queue.
  assign wr_drop = wr & ~|(wr_target & out_enq_rdy);

  for (genvar i = 0; i < nchan; i++) begin : g_chan
    assign wr_target[i] = wr & (wr_addr == ABITS'(i));

    vc_Queue #(.p_msg_nbits(PW), .p_num_msgs(num_entries)) out_q (
      .clk              (clk),
      .reset            (reset),
      .enq_val          (wr_target[i]),
      .enq_rdy          (out_enq_rdy[i]),
      .enq_msg          (wr_payload),
      .deq_val          (send_val[i]),
      .deq_rdy          (send_rdy[i]),
      .deq_msg          (send_msg[i*PW +: PW]),
      .num_free_entries (out_free[i])
    );

    vc_Queue #(.p_msg_nbits(PW), .p_num_msgs(num_entries)) in_q (
      .clk              (clk),
      .reset            (reset),
      .enq_val          (recv_val[i]),
      .enq_rdy          (in_enq_rdy[i]),
      .enq_msg          (recv_msg[i*PW +: PW]),
      .deq_val          (in_deq_val[i]),
      .deq_rdy          (pop_rd & grant[i]),
      .deq_msg          (in_head[i]),
      .num_free_entries (in_free[i])
    );

    assign recv_rdy[i] = in_enq_rdy[i] & (in_free[i] != '0);
    assign parity[i]   = send_val[i] & (^send_msg[i*PW +: PW]);
    // The last free slot only counts as space if this cycle's write is not already taking it.
    assign spc_ok[i]   = (out_free[i] > FW'(1)) | ((out_free[i] == FW'(1)) & ~wr_target[i]);
  end

  spi_rr_arbiter #(.nchan(nchan)) arb (
    .clk      (clk),
    .reset    (reset),
    .req      (in_deq_val),
    .advance  (pop_rd),
    .grant    (grant),
    .grant_id (grant_id),
    .any_req  (any_ne)
  );

  assign pop_rd        = rd & any_ne;
  assign pull_msg_val  = pop_rd;
  assign pull_msg_data = pop_rd ? {grant_id, in_head[grant_id]} : '0;
  assign pull_msg_spc  = ~reset | (&spc_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 2'b00;
    end else begin
      if (wr_drop)       err[ERR_WR] <= 1'b1;
      if (rd && !any_ne) err[ERR_RD] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_minion_adapter_mc.sv
// tb/tb_spi_minion_adapter_mc.sv - scoreboard bench for spi_minion_adapter_mc against a queue-level model
module tb_spi_minion_adapter_mc;

  localparam int NB  = 8;
  localparam int NCH = 2;
  localparam int NE  = 2;
  localparam int PW  = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              push_en = 1'b0;
  logic              push_msg_val_wrt = 1'b0;
  logic              push_msg_val_rd = 1'b0;
  logic [NB-3:0]     push_msg_data = '0;
  logic              pull_en = 1'b0;
  logic              pull_msg_val;
  logic              pull_msg_spc;
  logic [NB-3:0]     pull_msg_data;
  logic [NCH*PW-1:0] recv_msg = '0;
  logic [NCH-1:0]    recv_val = '0;
  logic [NCH-1:0]    recv_rdy;
  logic [NCH*PW-1:0] send_msg;
  logic [NCH-1:0]    send_val;
  logic [NCH-1:0]    send_rdy = '0;
  logic [NCH-1:0]    parity;
  logic [1:0]        err;

  spi_minion_adapter_mc #(.nbits(NB), .nchan(NCH), .num_entries(NE)) dut (
    .clk              (clk),
    .reset            (reset),
    .push_en          (push_en),
    .push_msg_val_wrt (push_msg_val_wrt),
    .push_msg_val_rd  (push_msg_val_rd),
    .push_msg_data    (push_msg_data),
    .pull_en          (pull_en),
    .pull_msg_val     (pull_msg_val),
    .pull_msg_spc     (pull_msg_spc),
    .pull_msg_data    (pull_msg_data),
    .recv_msg         (recv_msg),
    .recv_val         (recv_val),
    .recv_rdy         (recv_rdy),
    .send_msg         (send_msg),
    .send_val         (send_val),
    .send_rdy         (send_rdy),
    .parity           (parity),
    .err              (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] send_val;
    logic [NCH-1:0] recv_rdy;
    logic [NCH-1:0] parity;
    logic           spc;
    logic           pval;
    logic [1:0]     err;
  } stat_t;

  stat_t stat_q[$];
  int    pull_exp[$];
  int    send_exp[NCH][$];
  int    out_m[NCH][$];
  int    in_m[NCH][$];
  int    rr;
  logic [1:0] err_m;
  int    checks = 0;
  int    errors = 0;
  stat_t ms;
  logic  have;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle status plus data scoreboards popped on every DUT handshake.
  always @(negedge clk) begin
    have = 1'b0;
    if (stat_q.size() > 0) begin
      ms   = stat_q.pop_front();
      have = 1'b1;
      chk("send_val", int'(send_val), int'(ms.send_val));
      chk("recv_rdy", int'(recv_rdy), int'(ms.recv_rdy));
      chk("parity", int'(parity), int'(ms.parity));
      chk("pull_spc", int'(pull_msg_spc), int'(ms.spc));
      chk("pull_val", int'(pull_msg_val), int'(ms.pval));
      chk("err", int'(err), int'(ms.err));
      if (!ms.pval) chk("pull_data_zero", int'(pull_msg_data), 0);
    end
    if (pull_msg_val) begin
      if (pull_exp.size() == 0) chk("pull_unexpected", int'(pull_msg_val), 0);
      else chk("pull_data", int'(pull_msg_data), pull_exp.pop_front());
    end else if (have && ms.pval && pull_exp.size() > 0) begin
      void'(pull_exp.pop_front());
    end
    for (int c = 0; c < NCH; c++) begin
      if (send_val[c] && send_rdy[c]) begin
        if (send_exp[c].size() == 0) chk("send_unexpected", int'(send_val[c]), 0);
        else chk("send_data", int'(send_msg[c*PW +: PW]), send_exp[c].pop_front());
      end
    end
  end

  task automatic step(input logic pe, input logic wrt, input logic rdf, input logic [5:0] pd,
                      input logic pl, input logic [NCH-1:0] rv, input logic [NCH*PW-1:0] rm,
                      input logic [NCH-1:0] sr);
    stat_t s;
    int g, k, free, addr, pay;
    logic wr, rdr, wok;
    logic [PW-1:0] h;
    logic [NCH-1:0] in_acc;
    @(posedge clk);
    #1;
    reset = 1'b1;
    push_en = pe; push_msg_val_wrt = wrt; push_msg_val_rd = rdf; push_msg_data = pd;
    pull_en = pl; recv_val = rv; recv_msg = rm; send_rdy = sr;
    wr = pe & wrt;
    rdr = pl & rdf;
    addr = int'(pd[5]);
    pay = int'(pd[4:0]);
    s = '0;
    s.err = err_m;
    s.spc = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      s.send_val[c] = out_m[c].size() > 0;
      h = s.send_val[c] ? PW'(out_m[c][0]) : '0;
      s.parity[c] = ^h;
      s.recv_rdy[c] = in_m[c].size() < NE;
      free = NE - out_m[c].size();
      if (!(free > 1 || (free == 1 && !(wr && addr == c)))) s.spc = 1'b0;
    end
    g = -1;
    for (int i = 0; i < NCH; i++) begin
      k = (rr + i) % NCH;
      if (g < 0 && in_m[k].size() > 0) g = k;
    end
    s.pval = rdr && (g >= 0);
    if (s.pval) pull_exp.push_back((g << PW) | in_m[g][0]);
    stat_q.push_back(s);
    wok = wr && addr < NCH && out_m[addr].size() < NE;
    for (int c = 0; c < NCH; c++) in_acc[c] = rv[c] && in_m[c].size() < NE;
    for (int c = 0; c < NCH; c++)
      if (sr[c] && out_m[c].size() > 0) void'(out_m[c].pop_front());
    if (wok) begin
      out_m[addr].push_back(pay);
      send_exp[addr].push_back(pay);
    end else if (wr) begin
      err_m[0] = 1'b1;
    end
    if (s.pval) begin
      void'(in_m[g].pop_front());
      rr = (g + 1) % NCH;
    end else if (rdr) begin
      err_m[1] = 1'b1;
    end
    for (int c = 0; c < NCH; c++)
      if (in_acc[c]) in_m[c].push_back(int'(rm[c*PW +: PW]));
  endtask

  task automatic do_reset(input int n);
    stat_t s;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      push_en = 1'b0; push_msg_val_wrt = 1'b0; push_msg_val_rd = 1'b0; push_msg_data = '0;
      pull_en = 1'b0; recv_val = '0; recv_msg = '0; send_rdy = '0;
      for (int c = 0; c < NCH; c++) begin
        out_m[c].delete();
        in_m[c].delete();
        send_exp[c].delete();
      end
      pull_exp.delete();
      rr = 0;
      err_m = 2'b00;
      s = '0;
      s.recv_rdy = '1;
      s.spc = 1'b1;
      stat_q.push_back(s);
    end
  endtask

  task automatic idle(input logic [NCH-1:0] sr);
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, '0, '0, sr);
  endtask

  task automatic pull_rd();
    step(1'b1, 1'b0, 1'b1, 6'd0, 1'b1, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rr = 0;
    err_m = 2'b00;
    do_reset(2);

    idle('0);

    step(1'b1, 1'b1, 1'b0, 6'b1_10101, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 6'b1_00011, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("tp2_slice", int'(send_msg[9:5]), 5'b10101);
    chk("tp2_parity", int'(parity), 2'b10);
    chk("tp2_spc", int'(pull_msg_spc), 0);

    step(1'b1, 1'b1, 1'b0, 6'b1_00111, 1'b0, '0, '0, '0);
    idle(2'b10);
    @(negedge clk);
    chk("tp3_err", int'(err), 2'b01);
    chk("tp3_ch0", int'(send_val[0]), 0);
    idle(2'b10);

    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'b11, {5'h1F, 5'h03}, '0);
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'b01, {5'h00, 5'h04}, '0);
    pull_rd();
    @(negedge clk);
    chk("tp4_pull0", int'(pull_msg_data), 6'b0_00011);
    pull_rd();
    @(negedge clk);
    chk("tp4_pull1", int'(pull_msg_data), 6'b1_11111);
    pull_rd();
    @(negedge clk);
    chk("tp4_pull2", int'(pull_msg_data), 6'b0_00100);
    pull_rd();
    @(negedge clk);
    chk("tp4_empty", int'(pull_msg_val), 0);

    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'b10, {5'h11, 5'h00}, '0);
    @(negedge clk);
    chk("tp4_err_rd", int'(err[1]), 1);
    step(1'b1, 1'b1, 1'b1, 6'b0_01010, 1'b1, '0, '0, '0);
    @(negedge clk);
    chk("tp5_pull", int'(pull_msg_data), 6'b1_10001);
    idle('0);
    @(negedge clk);
    chk("tp5_send", int'(send_msg[4:0]), 5'b01010);

    step(1'b1, 1'b1, 1'b0, 6'b1_00001, 1'b0, 2'b11, {5'h07, 5'h09}, '0);
    idle('0);
    do_reset(1);
    @(negedge clk);
    chk("tp6_send_val", int'(send_val), 0);
    chk("tp6_err", int'(err), 0);
    do_reset(1);
    pull_rd();
    idle(2'b11);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset(1);
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             6'($urandom), 1'($urandom_range(0, 1)), NCH'($urandom), (NCH*PW)'($urandom),
             NCH'($urandom));
      end
    end
    idle('0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
